hazard_perf_counters: RTL and testbench

- Consumes the per-cycle hazard classification produced by the ID-stage hazard detector.
- Maintains the 64-bit RISC-V performance counters: mcycle, minstret, load-use stall count and branch flush count.
- Exposes the counters through a read port driven by the CSR/EXE datapath.
- Sits beside the pipeline as the receiving end of the 2-bit hazard-type code.

---
 rtl/hazard_perf_counters_pkg.sv | 26 ++
 rtl/hazard_perf_counters_if.sv | 13 +
 rtl/hazard_perf_counters_counter64.sv | 26 ++
 rtl/hazard_perf_counters.sv | 91 +++++++++
 tb/tb_hazard_perf_counters.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_perf_counters_pkg.sv
// perf_pkg: hazard codes, counter CSR addresses and default parameters
// shared by hazard_perf_counters and its bench.
package perf_pkg;
    typedef enum logic [1:0] {
        HZ_BRANCH   = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_NONE     = 2'd2,
        HZ_RSVD     = 2'd3
    } hazard_type_e;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_LDUSE     = 12'hC03;
    localparam logic [11:0] CSR_LDUSEH    = 12'hC83;
    localparam logic [11:0] CSR_BRANCH    = 12'hC04;
    localparam logic [11:0] CSR_BRANCHH   = 12'hC84;

    localparam int DEFAULT_RETIRE_DELAY = 3;
    localparam int DEFAULT_FILL_CYCLES  = 1;
endpackage

// File: rtl/hazard_perf_counters_if.sv
// hazard_perf_counters_if: hazard code input plus CSR read/write port of the
// performance counter block; the pipeline side is master.
interface hazard_perf_counters_if;
    logic [1:0]  CSR_type;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_we;
    logic [31:0] csr_wdata;

    modport master (output CSR_type, csr_addr, csr_we, csr_wdata, input csr_rdata, csr_hit);
    modport slave  (input CSR_type, csr_addr, csr_we, csr_wdata, output csr_rdata, csr_hit);
endinterface

// File: rtl/hazard_perf_counters_counter64.sv
// perf_counter64: 64-bit wrapping counter with independently writable halves;
// a write to one half wins over the increment and freezes the other half's carry.
module perf_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);
    logic [63:0] cnt_d, cnt_q, sum;

    always_comb begin
        sum = cnt_q + {63'd0, inc};
        cnt_d[31:0] = we_lo ? wdata : sum[31:0];
        cnt_d[63:32] = we_hi ? wdata : we_lo ? cnt_q[63:32] : sum[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: mcycle/minstret/load-use/branch counters fed by the ID hazard code.
// Define PERF_CSR_WRITE_EN to make the machine-mode cycle/instret halves writable.
module hazard_perf_counters
    import perf_pkg::*;
#(
    parameter int RETIRE_DELAY = DEFAULT_RETIRE_DELAY,
    parameter int FILL_CYCLES  = DEFAULT_FILL_CYCLES
) (
    input logic clk,
    input logic rst,
    hazard_perf_counters_if.slave bus
);
    localparam int FW = $clog2(FILL_CYCLES + 2);

    hazard_type_e hz;
    logic [FW-1:0] fill_d, fill_q;
    logic [RETIRE_DELAY-1:0] dly_d, dly_q;
    logic token;
    logic [63:0] mcycle, minstret, ld_use, branch;
    logic mcyc_we_lo, mcyc_we_hi, minst_we_lo, minst_we_hi;

    assign hz = hazard_type_e'(bus.CSR_type);

    // Only a normal advance after pipeline fill puts an instruction on its way to WB.
    always_comb begin
        token = hz == HZ_NONE && fill_q == '0;
        fill_d = fill_q == '0 ? fill_q : fill_q - FW'(1);
        dly_d = (dly_q << 1) | RETIRE_DELAY'(token);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= FW'(FILL_CYCLES);
            dly_q <= '0;
        end else begin
            fill_q <= fill_d;
            dly_q <= dly_d;
        end
    end

`ifdef PERF_CSR_WRITE_EN
    always_comb begin
        mcyc_we_lo = bus.csr_we && bus.csr_addr == CSR_MCYCLE;
        mcyc_we_hi = bus.csr_we && bus.csr_addr == CSR_MCYCLEH;
        minst_we_lo = bus.csr_we && bus.csr_addr == CSR_MINSTRET;
        minst_we_hi = bus.csr_we && bus.csr_addr == CSR_MINSTRETH;
    end
`else
    logic unused_we;
    assign unused_we = bus.csr_we;
    always_comb begin
        mcyc_we_lo = 1'b0;
        mcyc_we_hi = 1'b0;
        minst_we_lo = 1'b0;
        minst_we_hi = 1'b0;
    end
`endif

    perf_counter64 u_mcycle (
        .clk(clk), .rst(rst), .inc(1'b1), .we_lo(mcyc_we_lo), .we_hi(mcyc_we_hi),
        .wdata(bus.csr_wdata), .cnt(mcycle)
    );
    perf_counter64 u_minstret (
        .clk(clk), .rst(rst), .inc(dly_q[RETIRE_DELAY-1]), .we_lo(minst_we_lo), .we_hi(minst_we_hi),
        .wdata(bus.csr_wdata), .cnt(minstret)
    );
    perf_counter64 u_ld_use (
        .clk(clk), .rst(rst), .inc(hz == HZ_LOAD_USE), .we_lo(1'b0), .we_hi(1'b0),
        .wdata(32'd0), .cnt(ld_use)
    );
    perf_counter64 u_branch (
        .clk(clk), .rst(rst), .inc(hz == HZ_BRANCH), .we_lo(1'b0), .we_hi(1'b0),
        .wdata(32'd0), .cnt(branch)
    );

    always_comb begin
        bus.csr_hit = 1'b1;
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            CSR_CYCLE, CSR_MCYCLE:       bus.csr_rdata = mcycle[31:0];
            CSR_CYCLEH, CSR_MCYCLEH:     bus.csr_rdata = mcycle[63:32];
            CSR_INSTRET, CSR_MINSTRET:   bus.csr_rdata = minstret[31:0];
            CSR_INSTRETH, CSR_MINSTRETH: bus.csr_rdata = minstret[63:32];
            CSR_LDUSE:                   bus.csr_rdata = ld_use[31:0];
            CSR_LDUSEH:                  bus.csr_rdata = ld_use[63:32];
            CSR_BRANCH:                  bus.csr_rdata = branch[31:0];
            CSR_BRANCHH:                 bus.csr_rdata = branch[63:32];
            default:                     bus.csr_hit = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_hazard_perf_counters.sv
// tb_hazard_perf_counters: directed stimulus with an event-level counter model
// checked every cycle, plus hand-computed literal reads.
module tb_hazard_perf_counters;
    import perf_pkg::*;
    localparam int RD = 3;
    localparam int FILL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    hazard_perf_counters_if bus();
    hazard_perf_counters #(.RETIRE_DELAY(RD), .FILL_CYCLES(FILL)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    longint unsigned m_cyc = 0, m_ret = 0, m_ldu = 0, m_br = 0;
    bit tq[$];
    int since = 0;

    logic [11:0] sweep [13] = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC83,
                                12'hC04, 12'hC84, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h300};
    int sidx = 0;

    function automatic logic [32:0] expect_rd(input logic [11:0] a);
        case (a)
            12'hC00, 12'hB00: return {1'b1, m_cyc[31:0]};
            12'hC80, 12'hB80: return {1'b1, m_cyc[63:32]};
            12'hC02, 12'hB02: return {1'b1, m_ret[31:0]};
            12'hC82, 12'hB82: return {1'b1, m_ret[63:32]};
            12'hC03:          return {1'b1, m_ldu[31:0]};
            12'hC83:          return {1'b1, m_ldu[63:32]};
            12'hC04:          return {1'b1, m_br[31:0]};
            12'hC84:          return {1'b1, m_br[63:32]};
            default:          return 33'd0;
        endcase
    endfunction

    // Model: tokens queue up for RD edges, then count as retired.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cyc = 0; m_ret = 0; m_ldu = 0; m_br = 0;
            tq.delete();
            since = 0;
        end else begin : upd
            bit tok, ret;
            longint unsigned nc, nr;
            tok = bus.CSR_type == 2'd2 && since >= FILL;
            if (since < FILL) since++;
            ret = 1'b0;
            if (tq.size() == RD) ret = tq.pop_front();
            tq.push_back(tok);
            nc = m_cyc + 1;
            nr = m_ret + ret;
`ifdef PERF_CSR_WRITE_EN
            if (bus.csr_we)
                case (bus.csr_addr)
                    12'hB00: nc = {m_cyc[63:32], bus.csr_wdata};
                    12'hB80: nc = {bus.csr_wdata, nc[31:0]};
                    12'hB02: nr = {m_ret[63:32], bus.csr_wdata};
                    12'hB82: nr = {bus.csr_wdata, nr[31:0]};
                    default: ;
                endcase
`endif
            m_cyc = nc;
            m_ret = nr;
            if (bus.CSR_type == 2'd1) m_ldu++;
            if (bus.CSR_type == 2'd0) m_br++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin : cmp
            logic [32:0] e;
            e = expect_rd(bus.csr_addr);
            checks++;
            if ({bus.csr_hit, bus.csr_rdata} !== e) begin
                errors++;
                $display("FAIL model_cmp addr=%h got hit=%b data=%h expected hit=%b data=%h",
                         bus.csr_addr, bus.csr_hit, bus.csr_rdata, e[32], e[31:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] a, input logic hit, input logic [31:0] d);
        bus.csr_addr = a;
        #1;
        checks++;
        if (bus.csr_hit !== hit || bus.csr_rdata !== d) begin
            errors++;
            $display("FAIL %s addr=%h got hit=%b data=%h expected hit=%b data=%h",
                     name, a, bus.csr_hit, bus.csr_rdata, hit, d);
        end
    endtask

    task automatic cyc(input logic [1:0] code);
        bus.CSR_type = code;
        bus.csr_we = 1'b0;
        bus.csr_addr = sweep[sidx % 13];
        sidx++;
        @(posedge clk);
        #1;
    endtask

    task automatic wcyc(input logic [1:0] code, input logic [11:0] a, input logic [31:0] d);
        bus.CSR_type = code;
        bus.csr_we = 1'b1;
        bus.csr_addr = a;
        bus.csr_wdata = d;
        @(posedge clk);
        #1;
        bus.csr_we = 1'b0;
    endtask

    logic [1:0] pat [6] = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2};

    initial begin
        bus.CSR_type = 2'd3;
        bus.csr_addr = 12'hC00;
        bus.csr_we = 1'b0;
        bus.csr_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cycle", 12'hC00, 1'b1, 32'd0);
        chk("rst_instret", 12'hC02, 1'b1, 32'd0);
        chk("rst_lduse", 12'hC03, 1'b1, 32'd0);
        chk("rst_branch_hi", 12'hC84, 1'b1, 32'd0);

        repeat (10) cyc(2'd2);
        chk("fill_cycle", 12'hC00, 1'b1, 32'd10);
        chk("fill_instret", 12'hC02, 1'b1, 32'd6);
        chk("fill_minstret", 12'hB02, 1'b1, 32'd6);
        chk("fill_instret_hi", 12'hC82, 1'b1, 32'd0);

        foreach (pat[i]) cyc(pat[i]);
        repeat (5) cyc(2'd3);
        chk("mix_lduse", 12'hC03, 1'b1, 32'd1);
        chk("mix_branch", 12'hC04, 1'b1, 32'd2);
        chk("mix_instret", 12'hC02, 1'b1, 32'd12);
        chk("mix_cycle", 12'hC00, 1'b1, 32'd21);
        chk("mix_lduse_hi", 12'hC83, 1'b1, 32'd0);

`ifdef PERF_CSR_WRITE_EN
        wcyc(2'd3, 12'hB80, 32'd0);
        wcyc(2'd3, 12'hB00, 32'hFFFF_FFFF);
        chk("preload_lo", 12'hC00, 1'b1, 32'hFFFF_FFFF);
        chk("preload_hi", 12'hC80, 1'b1, 32'd0);
        cyc(2'd3);
        chk("carry_hi", 12'hC80, 1'b1, 32'd1);
        chk("carry_lo", 12'hC00, 1'b1, 32'd0);
        wcyc(2'd3, 12'hC02, 32'h1234);
        chk("user_write_ignored", 12'hC02, 1'b1, 32'd12);
`else
        wcyc(2'd3, 12'hB00, 32'hFFFF_FFFF);
        chk("ro_write_ignored", 12'hC00, 1'b1, 32'd22);
`endif

        repeat (4) cyc(2'd2);
        rst = 1'b1;
        chk("async_rst_cycle", 12'hC00, 1'b1, 32'd0);
        chk("async_rst_cycle_hi", 12'hC80, 1'b1, 32'd0);
        chk("async_rst_instret", 12'hC02, 1'b1, 32'd0);
        chk("async_rst_lduse", 12'hC03, 1'b1, 32'd0);
        chk("async_rst_branch", 12'hC04, 1'b1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cyc(2'd3);
        chk("no_late_retire", 12'hC02, 1'b1, 32'd0);
        chk("post_rst_cycle", 12'hC00, 1'b1, 32'd3);

        repeat (5) cyc(2'd2);
        chk("pre_write_instret", 12'hC02, 1'b1, 32'd2);
        wcyc(2'd2, 12'hB02, 32'h55);
`ifdef PERF_CSR_WRITE_EN
        chk("write_beats_retire", 12'hC02, 1'b1, 32'h55);
        chk("write_hi_kept", 12'hC82, 1'b1, 32'd0);
`else
        chk("retire_despite_we", 12'hC02, 1'b1, 32'd3);
`endif

        chk("unmapped_300", 12'h300, 1'b0, 32'd0);
        chk("unmapped_c01", 12'hC01, 1'b0, 32'd0);
        chk("unmapped_b03", 12'hB03, 1'b0, 32'd0);
        chk("unmapped_b84", 12'hB84, 1'b0, 32'd0);

        repeat (4) cyc(2'd1);
        repeat (13) cyc(2'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
